// File: rtl/vtx1_mem_arbiter.sv
// vtx1_mem_arbiter: two-port SRAM arbiter and strobe sequencer; define VTX1_MEM_ARB_RR_EN for round-robin, else port 0 has fixed priority
module vtx1_mem_arbiter #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W = 36,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, grant_q, grant_d, win;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
  logic mem_cs_n_q, mem_cs_n_d, mem_oe_n_q, mem_oe_n_d, mem_we_n_q, mem_we_n_d;
  logic mem_data_oe_q, mem_data_oe_d;
`ifdef VTX1_MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  always_comb begin
    win = (req0 && req1) ? !last_grant_q : !req0;
    last_grant_d = (state_q == IDLE && (req0 || req1)) ? win : last_grant_q;
  end
  always_ff @(posedge clk) last_grant_q <= rst ? 1'b1 : last_grant_d;
`else
  always_comb win = !req0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    grant_d = grant_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d = SETUP;
        grant_d = win;
        we_d = win ? we1 : we0;
        mem_addr_d = win ? addr1 : addr0;
        mem_wdata_d = win ? wdata1 : wdata0;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d = 4'(WAIT_STATES);
      end
      STROBE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = RECOVER;
          rdata_d = we_q ? rdata_q : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    // all bus outputs are registered copies of what the next state demands
    busy_d = state_d != IDLE;
    mem_cs_n_d = state_d == IDLE;
    mem_oe_n_d = !(state_d == STROBE && !we_d);
    mem_we_n_d = !(state_d == STROBE && we_d);
    mem_data_oe_d = state_d != IDLE && we_d;
    ack0_d = state_d == RECOVER && !grant_d;
    ack1_d = state_d == RECOVER && grant_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      grant_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      busy_q <= 1'b0;
      mem_cs_n_q <= 1'b1;
      mem_oe_n_q <= 1'b1;
      mem_we_n_q <= 1'b1;
      mem_data_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      grant_q <= grant_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q <= rdata_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      busy_q <= busy_d;
      mem_cs_n_q <= mem_cs_n_d;
      mem_oe_n_q <= mem_oe_n_d;
      mem_we_n_q <= mem_we_n_d;
      mem_data_oe_q <= mem_data_oe_d;
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign rdata = rdata_q;
  assign busy = busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_data_oe = mem_data_oe_q;
  assign mem_cs_n = mem_cs_n_q;
  assign mem_oe_n = mem_oe_n_q;
  assign mem_we_n = mem_we_n_q;
endmodule

// File: tb/tb_vtx1_mem_arbiter.sv
// tb_vtx1_mem_arbiter: vectors, corner sequences and a randomized transaction-level model for vtx1_mem_arbiter
`timescale 1ns/1ps
module tb_vtx1_mem_arbiter;
  localparam int WS = 2;
`ifdef VTX1_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [35:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, busy, mem_data_oe, mem_cs_n, mem_oe_n, mem_we_n;
  logic [35:0] rdata, mem_addr, mem_wdata, mem_rdata = '0;
  logic b_req = 0;
  logic [35:0] b_addr = '0, b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata = '0;
  logic b_ack0, b_ack1, b_busy, b_doe, b_cs_n, b_oe_n, b_we_n;

  vtx1_mem_arbiter #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_oe(mem_data_oe), .mem_rdata(mem_rdata), .mem_cs_n(mem_cs_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n));

  vtx1_mem_arbiter #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req0(b_req), .we0(1'b0), .addr0(b_addr), .wdata0(36'h0),
    .req1(1'b0), .we1(1'b0), .addr1(36'h0), .wdata1(36'h0), .ack0(b_ack0), .ack1(b_ack1),
    .rdata(b_rdata), .busy(b_busy), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_data_oe(b_doe), .mem_rdata(b_mem_rdata), .mem_cs_n(b_cs_n),
    .mem_oe_n(b_oe_n), .mem_we_n(b_we_n));

  logic [35:0] sram [logic [35:0]];
  logic [35:0] refm [logic [35:0]];
  function automatic logic [35:0] init_val(input logic [35:0] a);
    return {a[17:0] ^ 18'h2A5A5, ~a[17:0]};
  endfunction
  function automatic logic [35:0] sram_rd(input logic [35:0] a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction
  function automatic logic [35:0] ref_rd(input logic [35:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction
  // asynchronous SRAM behaviour, evaluated mid-cycle away from the DUT's edge
  always @(negedge clk) begin
    if (!mem_cs_n && !mem_we_n && mem_data_oe) sram[mem_addr] = mem_wdata;
    mem_rdata = mem_oe_n ? 36'h0 : sram_rd(mem_addr);
    b_mem_rdata = b_oe_n ? 36'h0 : sram_rd(b_mem_addr);
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic port; logic we; logic [35:0] addr; logic [35:0] wdata;
    logic [35:0] exp_rd; int exp_oe; int exp_we; int exp_doe;
  } vec_t;
  vec_t v[6];

  task automatic xfer(input vec_t t);
    int oe = 0, wl = 0, doe = 0, bz = 0, cs = 0, bad = 0, wrong = 0, lat = 0;
    logic [35:0] rd = '0;
    @(negedge clk);
    if (t.port) begin req1 = 1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; end
    else begin req0 = 1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; end
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (!mem_oe_n) oe++;
      if (!mem_we_n) wl++;
      if (mem_data_oe) doe++;
      if (busy) bz++;
      if (!mem_cs_n) cs++;
      if (!mem_cs_n && mem_addr !== t.addr) bad++;
      if (!mem_we_n && mem_wdata !== t.wdata) bad++;
      if (t.port ? ack0 : ack1) wrong++;
      if (t.port ? ack1 : ack0) begin lat = n; rd = rdata; end
    end
    req0 = 0; req1 = 0;
    chk("vec_latency", 64'(lat), 64'(WS + 3));
    chk("vec_rdata", 64'(rd), 64'(t.exp_rd));
    chk("vec_oe_low_cycles", 64'(oe), 64'(t.exp_oe));
    chk("vec_we_low_cycles", 64'(wl), 64'(t.exp_we));
    chk("vec_data_oe_cycles", 64'(doe), 64'(t.exp_doe));
    chk("vec_busy_cycles", 64'(bz), 64'(WS + 3));
    chk("vec_cs_low_cycles", 64'(cs), 64'(WS + 3));
    chk("vec_addr_data_stable", 64'(bad), 64'd0);
    chk("vec_wrong_port_ack", 64'(wrong), 64'd0);
  endtask

  int ack_cyc[$], ack_port[$];
  int cs_hi, both, tail, acks, b_lat, b_oe;
  logic [35:0] b_rd;
  int free_at, a_cyc, a_port, last_g, g;
  logic a_we, pend0, pend1;
  logic [35:0] a_val, exp_rd, ga, gd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{1'b0, 1'b0, 36'h0,  36'h0,          36'h123456789, 3, 0, 0};
    v[1] = '{1'b1, 1'b1, 36'h10, 36'h987654321,  36'h123456789, 0, 3, 5};
    v[2] = '{1'b0, 1'b0, 36'h10, 36'h0,          36'h987654321, 3, 0, 0};
    v[3] = '{1'b1, 1'b0, 36'h10, 36'h0,          36'h987654321, 3, 0, 0};
    v[4] = '{1'b0, 1'b1, 36'h3,  36'hABCDEF012,  36'h987654321, 0, 3, 5};
    v[5] = '{1'b1, 1'b0, 36'h3,  36'h0,          36'hABCDEF012, 3, 0, 0};
    sram[36'h0] = 36'h123456789;
    repeat (3) @(negedge clk);
    chk("rst_ack0", 64'(ack0), 64'd0);
    chk("rst_ack1", 64'(ack1), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cs_n", 64'(mem_cs_n), 64'd1);
    chk("rst_oe_n", 64'(mem_oe_n), 64'd1);
    chk("rst_we_n", 64'(mem_we_n), 64'd1);
    chk("rst_data_oe", 64'(mem_data_oe), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_b_cs_n", 64'(b_cs_n), 64'd1);
    rst = 0;
    for (int i = 0; i < 6; i++) xfer(v[i]);
    @(negedge clk);
    chk("sram_after_write", 64'(sram_rd(36'h10)), 64'h987654321);

    // contention: both ports hold read requests for four accesses
    rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    req0 = 1; we0 = 0; addr0 = 36'h20; req1 = 1; we1 = 0; addr1 = 36'h21;
    cs_hi = 0; both = 0; tail = 0;
    for (int n = 1; n <= 80 && ack_cyc.size() < 4; n++) begin
      @(negedge clk);
      if (ack0 && ack1) both++;
      if (ack_cyc.size() > 0 && mem_cs_n) cs_hi++;
      if (ack0 || ack1) begin ack_cyc.push_back(n); ack_port.push_back(int'(ack1)); end
    end
    req0 = 0;
    chk("cont_ack_count", 64'(ack_cyc.size()), 64'd4);
    for (int i = 0; i < ack_cyc.size(); i++) begin
      chk("cont_grant_port", 64'(ack_port[i]), RR ? 64'(i % 2) : 64'd0);
      chk("cont_ack_cycle", 64'(ack_cyc[i]), 64'(5 + 6 * i));
    end
    chk("cont_cs_high_gaps", 64'(cs_hi), 64'd3);
    for (int n = 1; n <= 20 && tail == 0; n++) begin
      @(negedge clk);
      if (ack0 && ack1) both++;
      if (ack0) tail = -1;
      else if (ack1) tail = n;
    end
    req1 = 0;
    chk("cont_tail_ack1", 64'(tail), 64'd6);
    chk("cont_simultaneous_ack", 64'(both), 64'd0);

    // reset during the second STROBE cycle of a write
    @(negedge clk); @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 36'h40; wdata0 = 36'h0F0F0F0F0;
    repeat (3) @(negedge clk);
    chk("rmid_we_low_before", 64'(mem_we_n), 64'd0);
    rst = 1; req0 = 0;
    @(negedge clk);
    chk("rmid_we_n", 64'(mem_we_n), 64'd1);
    chk("rmid_cs_n", 64'(mem_cs_n), 64'd1);
    chk("rmid_data_oe", 64'(mem_data_oe), 64'd0);
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_addr", 64'(mem_addr), 64'd0);
    chk("rmid_rdata", 64'(rdata), 64'd0);
    rst = 0; acks = 0;
    repeat (12) begin @(negedge clk); if (ack0 || ack1) acks++; end
    chk("rmid_no_ack", 64'(acks), 64'd0);

    // zero wait states on the second instance
    b_req = 1; b_addr = 36'h5; b_lat = 0; b_oe = 0; b_rd = '0;
    for (int n = 1; n <= 10 && b_lat == 0; n++) begin
      @(negedge clk);
      if (!b_oe_n) b_oe++;
      if (b_ack0) begin b_lat = n; b_rd = b_rdata; end
    end
    b_req = 0;
    chk("ws0_latency", 64'(b_lat), 64'd3);
    chk("ws0_oe_low_cycles", 64'(b_oe), 64'd1);
    chk("ws0_rdata", 64'(b_rd), 64'(init_val(36'h5)));

    // randomized traffic against a transaction-level model
    rst = 1; @(negedge clk); rst = 0;
    free_at = 0; a_cyc = -1; a_port = 0; a_we = 0; a_val = '0; exp_rd = '0;
    last_g = 1; pend0 = 0; pend1 = 0;
    for (int k = 0; k < 1530; k++) begin
      if (k > 0) @(negedge clk);
      chk("rand_ack0", 64'(ack0), 64'(k == a_cyc && a_port == 0));
      chk("rand_ack1", 64'(ack1), 64'(k == a_cyc && a_port == 1));
      if (k == a_cyc && !a_we) exp_rd = a_val;
      chk("rand_rdata", 64'(rdata), 64'(exp_rd));
      if (k == a_cyc) begin if (a_port == 1) pend1 = 0; else pend0 = 0; end
      if (!pend0) begin
        if (k < 1500 && $urandom_range(0, 2) == 0) begin
          pend0 = 1; req0 = 1; we0 = 1'($urandom_range(0, 1));
          addr0 = 36'h100 + 36'($urandom_range(0, 7)); wdata0 = 36'({$urandom(), $urandom()});
        end else req0 = 0;
      end
      if (!pend1) begin
        if (k < 1500 && $urandom_range(0, 2) == 0) begin
          pend1 = 1; req1 = 1; we1 = 1'($urandom_range(0, 1));
          addr1 = 36'h100 + 36'($urandom_range(0, 7)); wdata1 = 36'({$urandom(), $urandom()});
        end else req1 = 0;
      end
      if (k >= free_at && (req0 || req1)) begin
        g = (req0 && req1) ? (RR ? 1 - last_g : 0) : int'(req1);
        last_g = g;
        a_we = g == 1 ? we1 : we0;
        ga = g == 1 ? addr1 : addr0;
        gd = g == 1 ? wdata1 : wdata0;
        a_cyc = k + WS + 3; a_port = g; free_at = k + WS + 4;
        if (a_we) refm[ga] = gd; else a_val = ref_rd(ga);
      end
    end
    req0 = 0; req1 = 0;
    for (int i = 0; i < 8; i++) chk("rand_mem_final", 64'(sram_rd(36'h100 + 36'(i))), 64'(ref_rd(36'h100 + 36'(i))));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
